ibwt_lf_decoder: RTL and testbench
==================================

// Module: ibwt_lf_decoder
// PURPOSE
//  Inverse Burrows-Wheeler stage; sits directly downstream of the forward BWT stage.
//  Reads the len_str-byte BWT last column L from shared memory and rebuilds the original
//  string using LF-mapping. Writes the result back at OUT_BASE. Handshake: CS starts it, flag reports done.
// PARAMETERS
//  len_addr  10   memory address width; also the width of len_str, prim_idx and all counters
//  OUT_BASE  512  base write address of the reconstructed string
// PORTS
//  clk       in   1         single clock, rising edge
//  reset     in   1         synchronous, active-high
//  CS        in   1         start/select; sampled only in IDLE
//  len_str   in   len_addr  string length n; L occupies addr 0..n-1
//  prim_idx  in   len_addr  BWT primary index (row of the original string)
//  ren       out  1         memory read strobe
//  addr      out  len_addr  read address
//  din       in   8         read data, valid exactly 1 cycle after ren
//  wen       out  1         memory write strobe
//  addr1     out  len_addr  write address
//  dout      out  8         write data
//  flag      out  1         done; held high in DONE
//  err       out  1         prim_idx>=len_str (n>0); held high in DONE
// BEHAVIOUR
//  Reset: state=IDLE; ren, wen, flag, err=0; addr, addr1, dout=0. Reset mid-op aborts at once,
//   and no strobe is issued on the next cycle.
//  Internal storage: cnt[256] (len_addr bits each); rank[2^len_addr] (len_addr bits each).
//   Both are cleared or overwritten on every run.
//  IDLE: if CS=1 go to CLR; latch n=len_str and p=prim_idx.
//   If n==0 go straight to DONE (flag=1, no reads or writes).
//   If p>=n go to DONE with err=1, no writes.
//  CLR (1 cycle): all cnt cleared in parallel.
//  COUNT (2 cycles/byte, i=0..n-1):
//   cycle A: ren=1, addr=i.
//   cycle B: c=din; rank[i]<=cnt[c]; cnt[c]<=cnt[c]+1.
//  PREFIX (256 cycles, s=0..255): exclusive prefix sum in place, so cnt[s] becomes C[s].
//   C[s] = number of bytes < s. The running sum uses len_addr bits; it cannot overflow since n<2^len_addr.
//  WALK (2 cycles/char, k=n-1 down to 0):
//   cycle A: ren=1, addr=p.
//   cycle B: c=din; wen=1, addr1=OUT_BASE+k (mod 2^len_addr), dout=c; p<=C[c]+rank[p].
//  DONE: flag=1 (err as latched). Stays until CS=0, then returns to IDLE with flag and err cleared.
//   CS still high at DONE means no restart until CS drops.
//  Strobes: ren and wen are 1-cycle pulses, never high together. Both are 0 outside COUNT/WALK.
//  CS changes after start are ignored until DONE.
//  Latency: CS sampled at edge 0 -> flag high after edge 4n+257.
//  n=1: single read in COUNT, single write of L[0] to OUT_BASE.
// TESTING
//  L="nnbaaa", n=6, prim_idx=3 -> writes in order: a@517, n@516, a@515, n@514, a@513, b@512.
//   Memory then reads "banana"; flag rises 281 cycles after CS.
//  n=0, CS=1 -> flag on the cycle after DONE entry; zero ren/wen pulses; err=0.
//  L="aaaa", n=4, prim_idx=2 -> "aaaa" at 512..515.
//   Checks repeated-symbol ranks and the C[a]=0 path.
//  n=5, prim_idx=7 -> err=1, flag=1, no wen pulses.
//  Reset asserted during WALK of "nnbaaa" -> next cycle state IDLE, ren=wen=flag=0.
//   Rerun from CS gives a correct "banana".
//  Hold CS=1 after flag -> no restart. Drop CS -> flag=0.
//   Reassert CS -> second run decodes identically; cnt and rank are fully reinitialised.

Source files
------------

// File: rtl/ibwt_lf_decoder.sv
// Inverse BWT decoder: counts symbol ranks over the last column L, turns the counts
// into first-column offsets C[s], then walks LF-mapping backwards writing the string out.
//
// state  | meaning
// IDLE   | waiting for CS; latches n and primary index
// CLR    | clears all symbol counters in one cycle
// COUNT  | reads L[i] (phase 0), records rank and bumps cnt (phase 1)
// PREFIX | converts cnt[] into exclusive prefix sums C[] over 256 cycles
// WALK   | reads L[p] (phase 0), writes the char and follows LF (phase 1)
// DONE   | flag (and err) held until CS drops
module ibwt_lf_decoder #(
  parameter int len_addr = 10,
  parameter int OUT_BASE = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                CS,
  input  logic [len_addr-1:0] len_str,
  input  logic [len_addr-1:0] prim_idx,
  output logic                ren,
  output logic [len_addr-1:0] addr,
  input  logic [7:0]          din,
  output logic                wen,
  output logic [len_addr-1:0] addr1,
  output logic [7:0]          dout,
  output logic                flag,
  output logic                err
);

  typedef enum logic [2:0] {IDLE, CLR, COUNT, PREFIX, WALK, DONE} state_t;

  localparam logic [len_addr-1:0] ONE        = {{(len_addr-1){1'b0}}, 1'b1};
  localparam logic [len_addr-1:0] OUT_BASE_A = len_addr'(OUT_BASE);

  logic [len_addr-1:0] cnt_q  [256];
  logic [len_addr-1:0] rank_q [2**len_addr];

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [len_addr-1:0] idx_q, idx_d;
  logic [7:0]          s_q, s_d;
  logic [len_addr-1:0] sum_q, sum_d;
  logic [len_addr-1:0] n_q, n_d;
  logic [len_addr-1:0] p_q, p_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [len_addr-1:0] addr_q, addr_d;
  logic [len_addr-1:0] addr1_q, addr1_d;
  logic                flag_q, flag_d;
  logic                err_q, err_d;

  logic                cnt_clr, cnt_we, rank_we;
  logic [7:0]          cnt_wa;
  logic [len_addr-1:0] cnt_wd;
  logic [len_addr-1:0] next_p;

  assign next_p = cnt_q[din] + rank_q[p_q];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    s_d     = s_q;
    sum_d   = sum_q;
    n_d     = n_q;
    p_d     = p_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    addr1_d = addr1_q;
    flag_d  = flag_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_we  = 1'b0;
    cnt_wa  = din;
    cnt_wd  = cnt_q[din] + ONE;
    rank_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (CS) begin
          n_d = len_str;
          p_d = prim_idx;
          if (len_str == '0) begin
            state_d = DONE;
            flag_d  = 1'b1;
          end else if (prim_idx >= len_str) begin
            state_d = DONE;
            flag_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = CLR;
          end
        end
      end
      CLR: begin
        cnt_clr = 1'b1;
        state_d = COUNT;
        ren_d   = 1'b1;
        addr_d  = '0;
        idx_d   = '0;
        phase_d = 1'b0;
      end
      COUNT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          cnt_we  = 1'b1;
          rank_we = 1'b1;
          if (idx_q == n_q - ONE) begin
            state_d = PREFIX;
            s_d     = '0;
            sum_d   = '0;
          end else begin
            idx_d   = idx_q + ONE;
            ren_d   = 1'b1;
            addr_d  = idx_q + ONE;
            phase_d = 1'b0;
          end
        end
      end
      PREFIX: begin
        cnt_we = 1'b1;
        cnt_wa = s_q;
        cnt_wd = sum_q;
        sum_d  = sum_q + cnt_q[s_q];
        s_d    = s_q + 8'd1;
        if (s_q == 8'hff) begin
          state_d = WALK;
          ren_d   = 1'b1;
          addr_d  = p_q;
          idx_d   = n_q - ONE;
          phase_d = 1'b0;
        end
      end
      WALK: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          wen_d   = 1'b1;
          addr1_d = OUT_BASE_A + idx_q;
        end else begin
          p_d = next_p;
          if (idx_q == '0) begin
            state_d = DONE;
            flag_d  = 1'b1;
          end else begin
            idx_d   = idx_q - ONE;
            ren_d   = 1'b1;
            addr_d  = next_p;
            phase_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (!CS) begin
          state_d = IDLE;
          flag_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      sum_q   <= '0;
      n_q     <= '0;
      p_q     <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      addr1_q <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      n_q     <= n_d;
      p_q     <= p_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      addr1_q <= addr1_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cnt_clr) begin
      for (int j = 0; j < 256; j++) cnt_q[j] <= '0;
    end else if (cnt_we) begin
      cnt_q[cnt_wa] <= cnt_wd;
    end
    if (rank_we) rank_q[idx_q] <= cnt_q[din];
  end

  assign ren   = ren_q;
  assign wen   = wen_q;
  assign addr  = addr_q;
  assign addr1 = addr1_q;
  assign flag  = flag_q;
  assign err   = err_q;
  // The symbol only arrives in the write cycle, so it is forwarded straight from the read port.
  assign dout  = wen_q ? din : 8'h00;

endmodule

// File: tb/tb_ibwt_lf_decoder.sv
// Directed bench for ibwt_lf_decoder: vector table of L strings with expected decodes,
// plus hand sequences for reset-in-WALK, CS hold and rerun.
module tb_ibwt_lf_decoder;

  logic       clk = 1'b0;
  logic       reset, CS;
  logic [9:0] len_str, prim_idx, addr, addr1;
  logic       ren, wen, flag, err;
  logic [7:0] din, dout;

  ibwt_lf_decoder #(.len_addr(10), .OUT_BASE(512)) dut (
    .clk(clk), .reset(reset), .CS(CS), .len_str(len_str), .prim_idx(prim_idx),
    .ren(ren), .addr(addr), .din(din), .wen(wen), .addr1(addr1), .dout(dout),
    .flag(flag), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  int n_ren, n_wen, n_both;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    if (ren) begin
      din <= mem[addr];
      n_ren++;
    end
    if (wen) begin
      mem[addr1] <= dout;
      n_wen++;
    end
    if (ren && wen) n_both++;
  end

  typedef struct {
    logic [63:0] l;
    int          n;
    int          p;
    logic [63:0] exp_out;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic [63:0] l, int n, int p, logic [63:0] o, logic e, int lat);
    vec_t v;
    v.l = l; v.n = n; v.p = p; v.exp_out = o; v.exp_err = e; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  cyc;
    bit  got;
    bit  valid;
    int  r0;
    logic [63:0] o;
    @(negedge clk);
    for (int j = 0; j < 1024; j++) mem[j] <= 8'hEE;
    for (int j = 0; j < v.n; j++) mem[j] <= v.l[8*(v.n-1-j) +: 8];
    @(negedge clk);
    len_str  = 10'(v.n);
    prim_idx = 10'(v.p);
    CS       = 1'b1;
    n_ren = 0; n_wen = 0; n_both = 0;
    cyc = 0; got = 1'b0;
    while (cyc < 3000 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      if (flag) got = 1'b1;
    end
    valid = (v.n > 0) && !v.exp_err;
    chk({tag, " done"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(cyc - 1), 64'(v.exp_lat));
    chk({tag, " err"}, 64'(err), 64'(v.exp_err));
    chk({tag, " reads"}, 64'(n_ren), 64'(valid ? 2 * v.n : 0));
    chk({tag, " writes"}, 64'(n_wen), 64'(valid ? v.n : 0));
    chk({tag, " ren_wen_overlap"}, 64'(n_both), 64'd0);
    if (valid) begin
      o = '0;
      for (int j = 0; j < v.n; j++) o[8*(v.n-1-j) +: 8] = mem[512+j];
      chk({tag, " output"}, o, v.exp_out);
    end
    r0 = n_ren;
    repeat (10) @(posedge clk);
    #1;
    chk({tag, " hold_flag"}, 64'(flag), 64'd1);
    chk({tag, " hold_no_restart"}, 64'(n_ren - r0), 64'd0);
    @(negedge clk);
    CS = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " drop_flag"}, 64'(flag), 64'd0);
    chk({tag, " drop_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk("nnbaaa", 6, 3, "banana", 1'b0, 281);
    vecs[1] = mk("aaaa",   4, 2, "aaaa",   1'b0, 273);
    vecs[2] = mk(64'd0,    0, 0, 64'd0,    1'b0, 0);
    vecs[3] = mk(64'd0,    5, 7, 64'd0,    1'b1, 0);
    vecs[4] = mk("x",      1, 0, "x",      1'b0, 261);
    vecs[5] = mk("ba",     2, 0, "ab",     1'b0, 265);
    vecs[6] = mk(64'd0,    3, 3, 64'd0,    1'b1, 0);

    reset = 1'b1; CS = 1'b0; len_str = '0; prim_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ren", 64'(ren), 64'd0);
    chk("reset wen", 64'(wen), 64'd0);
    chk("reset flag", 64'(flag), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset addr", 64'(addr), 64'd0);
    chk("reset addr1", 64'(addr1), 64'd0);
    chk("reset dout", 64'(dout), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort in the middle of the walk
    @(negedge clk);
    for (int j = 0; j < 6; j++) mem[j] <= vecs[0].l[8*(5-j) +: 8];
    len_str = 10'd6; prim_idx = 10'd3; CS = 1'b1;
    repeat (275) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; CS = 1'b0;
    @(posedge clk);
    #1;
    chk("abort ren", 64'(ren), 64'd0);
    chk("abort wen", 64'(wen), 64'd0);
    chk("abort flag", 64'(flag), 64'd0);
    chk("abort dout", 64'(dout), 64'd0);
    n_ren = 0; n_wen = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort idle_no_strobes", 64'(n_ren + n_wen), 64'd0);
    chk("abort idle_flag", 64'(flag), 64'd0);

    run_vec(vecs[0], "rerun_after_abort");
    run_vec(vecs[1], "rerun_aaaa");
    run_vec(vecs[0], "rerun_banana");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
